// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared types for the shared-multiplier arbiter.
// Holds the FSM encoding and the operand/product widths.
package mul_share_pkg;

  localparam int OPW   = 32;
  localparam int PRODW = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_share_state_t;

endpackage

// File: rtl/VerilogMultiplier.sv
// VerilogMultiplier: combinational signed 32x32 multiplier.
// Full 64-bit two's-complement product, no rounding or truncation.
module VerilogMultiplier (
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [63:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mul_share_rr_pick.sv
// mul_share_rr_pick: combinational grant selection.
// Round-robin from ptr, or lowest index under MUL_SHARE_FIXED_PRIO_EN.
module mul_share_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

`ifdef MUL_SHARE_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // lowest valid index wins
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid[IDW'(i)]) begin
        gnt            = '0;
        gnt[IDW'(i)]   = 1'b1;
        gnt_id         = IDW'(i);
      end
    end
  end

`else

  // first valid index at or after ptr, wrapping
  always_comb begin
    logic found;
    int   idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && valid[IDW'(idx)]) begin
        found          = 1'b1;
        gnt[IDW'(idx)] = 1'b1;
        gnt_id         = IDW'(idx);
      end
    end
  end

`endif

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: one slow signed multiplier shared by NREQ units.
// Define MUL_SHARE_FIXED_PRIO_EN for fixed lowest-index priority.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_a,
  input  logic [NREQ*OPW-1:0]  req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [PRODW-1:0]     rsp_c,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  mul_share_state_t state_q;
  mul_share_state_t state_d;

  logic [CW-1:0]          cnt_q;
  logic signed [OPW-1:0]  a_q;
  logic signed [OPW-1:0]  b_q;
  logic [IDW-1:0]         id_q;
  logic [IDW-1:0]         ptr_q;
  logic signed [PRODW-1:0] prod;
  logic [NREQ-1:0]        gnt;
  logic [IDW-1:0]         gnt_id;
  logic                   idle;
  logic                   accept;

  assign idle   = (state_q == IDLE);
  assign accept = idle && (|req_valid);

  mul_share_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid  (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  VerilogMultiplier u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  assign req_ready = (rst && idle) ? gnt : '0;
  assign rsp_valid = (state_q == DONE);
  assign busy      = !idle;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state: accept, count down, wait for consumer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // operand capture, latency counter, product capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= '0;
      cnt_q  <= '0;
      rsp_c  <= '0;
      rsp_id <= '0;
    end else if (accept) begin
      a_q   <= req_a[int'(gnt_id)*OPW +: OPW];
      b_q   <= req_b[int'(gnt_id)*OPW +: OPW];
      id_q  <= gnt_id;
      cnt_q <= CW'(MUL_LAT - 1);
    end else if (state_q == CALC) begin
      if (cnt_q == '0) begin
        rsp_c  <= prod;
        rsp_id <= id_q;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

`ifdef MUL_SHARE_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  // rotate priority past the last accepted requester
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      if (gnt_id == IDW'(NREQ - 1)) ptr_q <= '0;
      else                          ptr_q <= gnt_id + IDW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench for mul_share_arbiter.
// Cycle model at negedge, directed cases then random traffic.
module tb_mul_share_arbiter;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 3;
  localparam int IDW     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a = '0;
  logic [NREQ*32-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [63:0]       rsp_c;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    c;
  } exp_t;

  exp_t            sbq[$];
  int              id_log[$];
  int              mphase = 0;
  int              mcnt = 0;
  int              mptr = 0;
  int              rsp_count = 0;
  int              rsp_id2_seen = 0;
  logic [NREQ-1:0] last_grant = '0;

  mul_share_arbiter #(
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic int winner(logic [NREQ-1:0] v, int p);
`ifdef MUL_SHARE_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return -1;
  endfunction

  function automatic int oh_idx(logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [63:0] mulref(logic [31:0] a,
                                         logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    return 64'(sa * sb);
  endfunction

  // reference model and scoreboard, evaluated mid-cycle
  always @(negedge clk) begin
    int              w;
    logic [NREQ-1:0] er;
    if (!rst) begin
      mphase = 0;
      mcnt = 0;
      mptr = 0;
      sbq.delete();
      last_grant = '0;
    end else begin
      w  = winner(req_valid, mptr);
      er = '0;
      if (mphase == 0 && w >= 0) er[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rsp_valid", 64'(rsp_valid), 64'(mphase == 2));
      chk("busy", 64'(busy), 64'(mphase != 0));
      last_grant = '0;
      if (mphase == 2) begin
        if (sbq.size() != 0) begin
          chk("rsp_c", rsp_c, sbq[0].c);
          chk("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
        end
        if (rsp_ready) begin
          if (sbq.size() != 0) void'(sbq.pop_front());
          rsp_count++;
          if (rsp_id == 2) rsp_id2_seen++;
          mphase = 0;
        end
      end else if (mphase == 1) begin
        mcnt--;
        if (mcnt == 0) mphase = 2;
      end else if (w >= 0) begin
        sbq.push_back({IDW'(w),
          mulref(req_a[w*32 +: 32], req_b[w*32 +: 32])});
        if (req_ready != '0) id_log.push_back(oh_idx(req_ready));
`ifndef MUL_SHARE_FIXED_PRIO_EN
        mptr = (w + 1) % NREQ;
`endif
        mphase = 1;
        mcnt = MUL_LAT;
        last_grant[w] = 1'b1;
      end
    end
  end

  // a granted requester drops its request after the edge
  always @(posedge clk) begin
    #1;
    req_valid = req_valid & ~last_grant;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(int i, logic [31:0] a, logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic wait_valid(int bound, output int n);
    n = 0;
    while (!rsp_valid && n < bound + 1) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      n_chk++;
      $display("FAIL wait_valid: timeout after %0d", n);
    end
  endtask

  task automatic wait_idle(int bound);
    int n;
    n = 0;
    while ((busy || req_valid != '0) && n < bound) begin
      tick();
      n++;
    end
    if (busy || req_valid != '0) begin
      n_chk++;
      $display("FAIL wait_idle: timeout busy=%0b", busy);
    end
  endtask

  task automatic op_check(string name, logic [31:0] a,
                          logic [31:0] b, logic [63:0] expc);
    int n;
    issue(0, a, b);
    wait_valid(20, n);
    chk(name, rsp_c, expc);
    tick();
    wait_idle(20);
  endtask

  function automatic logic [31:0] randop();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int n0;
    int rr_exp[5];

    #1 rst = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_c", rsp_c, 64'h0);
    chk("rst_rsp_id", 64'(rsp_id), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    rsp_ready = 1'b1;

    // basic op with latency
    issue(0, 32'hFFFF_FFFE, 32'd3);
    wait_valid(20, n);
    chk("basic_lat", 64'(n), 64'(MUL_LAT + 2));
    chk("basic_c", rsp_c, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("basic_id", 64'(rsp_id), 64'h0);
    tick();
    wait_idle(20);

    // extremes
    op_check("ext_min_sq", 32'h8000_0000, 32'h8000_0000,
             64'h4000_0000_0000_0000);
    op_check("ext_max_min", 32'h7FFF_FFFF, 32'h8000_0000,
             64'hC000_0000_8000_0000);
    op_check("ext_zero", 32'h0, 32'hDEAD_BEEF, 64'h0);

    // round-robin with all requesters valid
    do_reset();
    id_log.delete();
    n = 0;
    while (id_log.size() < 5 && n < 200) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i]) issue(i, $urandom, $urandom);
      tick();
      n++;
    end
    req_valid = '0;
    wait_idle(20);
`ifdef MUL_SHARE_FIXED_PRIO_EN
    rr_exp = '{0, 0, 0, 0, 0};
`else
    rr_exp = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      if (i < id_log.size())
        chk($sformatf("rr_grant%0d", i),
            64'(id_log[i]), 64'(rr_exp[i]));
      else
        chk($sformatf("rr_grant%0d", i), 64'hFF, 64'(rr_exp[i]));
    end

    // back-pressure
    rsp_ready = 1'b0;
    issue(1, $urandom, $urandom);
    tick();
    issue(2, $urandom, $urandom);
    wait_valid(20, n);
    repeat (10) begin
      tick();
      chk("bp_ready", 64'(req_ready), 64'h0);
      chk("bp_valid", 64'(rsp_valid), 64'h1);
    end
    n0 = rsp_count;
    rsp_ready = 1'b1;
    tick();
    chk("bp_one_rsp", 64'(rsp_count - n0), 64'h1);
    wait_idle(30);

    // reset mid-operation
    issue(3, $urandom, $urandom);
    tick();
    tick();
    chk("mid_busy", 64'(busy), 64'h1);
    req_valid = '1;
    n0 = rsp_count;
    rst = 1'b0;
    #1;
    chk("mid_req_ready", 64'(req_ready), 64'h0);
    chk("mid_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("mid_rsp_c", rsp_c, 64'h0);
    chk("mid_rsp_id", 64'(rsp_id), 64'h0);
    chk("mid_busy0", 64'(busy), 64'h0);
    @(negedge clk);
    @(posedge clk);
    #2;
    req_valid = '0;
    issue(0, 32'd5, 32'd7);
    issue(1, 32'd1, 32'd1);
    id_log.delete();
    rst = 1'b1;
    wait_idle(40);
    chk("mid_first_id",
        64'(id_log.size() > 0 ? id_log[0] : 99), 64'h0);
    chk("mid_rsp_count", 64'(rsp_count - n0), 64'h2);

    // withdrawn request
    do_reset();
    n0 = rsp_id2_seen;
    id_log.delete();
    issue(2, $urandom, $urandom);
    issue(3, $urandom, $urandom);
    #1;
    chk("wd_pre_grant", 64'(req_ready), 64'h4);
    #1;
    req_valid[2] = 1'b0;
    tick();
    wait_idle(20);
    chk("wd_grant",
        64'(id_log.size() > 0 ? id_log[0] : 99), 64'h3);
    chk("wd_no_id2", 64'(rsp_id2_seen - n0), 64'h0);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0)
            issue(i, randop(), randop());
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(40);
    chk("drain_empty", 64'(sbq.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
